pwm_audio_out: RTL



---
 rtl/pwm_audio_out.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pwm_audio_out.sv
// Single-bit PWM audio output with double-buffered sample capture and overrun flag.
// Define PWM_DITHER_EN to add first-order error-feedback dither on the truncated low bits.
module pwm_audio_out #(
    parameter int unsigned PWM_BITS = 10,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    input  logic [SAMPLE_W-1:0] data_in,
    input  logic                data_valid_in,
    input  logic                enable_in,
    input  logic                clear_overrun_in,
    output logic                pwm_out,
    output logic                overrun_out,
    output logic                period_start_out
);

    localparam int unsigned LowW = SAMPLE_W - PWM_BITS;

    localparam logic [PWM_BITS-1:0] CntMax     = {PWM_BITS{1'b1}};
    localparam logic [SAMPLE_W-1:0] SignBit    = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [PWM_BITS-1:0] MidDuty    = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] active_q, active_d;
    logic [SAMPLE_W-1:0] pending_q, pending_d;
    logic                pending_full_q, pending_full_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic                overrun_q, overrun_d;
    logic                pstart_q, pstart_d;

    logic                boundary;
    logic [SAMPLE_W-1:0] sample_offset;
    logic [SAMPLE_W-1:0] next_active;
    logic [PWM_BITS-1:0] next_duty;

    // Offset-binary: flipping the sign bit maps -32768..32767 onto 0..65535.
    assign sample_offset = data_in ^ SignBit;
    assign boundary      = enable_in && (cnt_q == CntMax);
    assign next_active   = pending_full_q ? pending_q : active_q;

`ifdef PWM_DITHER_EN
    logic [LowW-1:0]   err_q, err_d;
    logic [SAMPLE_W:0] dither_sum;

    always_comb begin
        dither_sum = {1'b0, next_active} + {{(PWM_BITS+1){1'b0}}, err_q};
        if (dither_sum[SAMPLE_W]) begin
            next_duty = CntMax;
        end else begin
            next_duty = dither_sum[SAMPLE_W-1 -: PWM_BITS];
        end
        err_d = err_q;
        // Runs every period, held samples included, so the residue keeps shaping.
        if (boundary) begin
            err_d = dither_sum[LowW-1:0];
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_low_bits;

    assign next_duty       = next_active[SAMPLE_W-1 -: PWM_BITS];
    assign unused_low_bits = ^next_active[LowW-1:0];
`endif

    always_comb begin
        cnt_d          = enable_in ? cnt_q + 1'b1 : '0;
        active_d       = active_q;
        duty_d         = duty_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;

        if (boundary) begin
            active_d       = next_active;
            duty_d         = next_duty;
            pending_full_d = 1'b0;
        end
        // A sample landing on the boundary refills the buffer just emptied.
        if (data_valid_in) begin
            pending_d      = sample_offset;
            pending_full_d = 1'b1;
        end

        overrun_d = overrun_q;
        if (clear_overrun_in) begin
            overrun_d = 1'b0;
        end
        if (data_valid_in && pending_full_q && !boundary) begin
            overrun_d = 1'b1;
        end

        pwm_d    = enable_in && (cnt_q < duty_q);
        pstart_d = enable_in && (cnt_q == '0);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cnt_q          <= '0;
            active_q       <= SignBit;
            pending_q      <= SignBit;
            pending_full_q <= 1'b0;
            duty_q         <= MidDuty;
            pwm_q          <= 1'b0;
            overrun_q      <= 1'b0;
            pstart_q       <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            duty_q         <= duty_d;
            pwm_q          <= pwm_d;
            overrun_q      <= overrun_d;
            pstart_q       <= pstart_d;
        end
    end

    assign pwm_out          = pwm_q;
    assign overrun_out      = overrun_q;
    assign period_start_out = pstart_q;

endmodule
